// File: rtl/s27_bist_pkg.sv
// rtl/s27_bist_pkg.sv - shared types, MISR/LFSR constants and step functions for the s27 BIST sequencer
package s27_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } bist_state_t;

  localparam int MISR_W = 16;
  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [MISR_W-1:0] MISR_TAPS = 16'hB400;

  localparam int LFSR_W = 4;
  // Feedback taps at bits 3 and 2; shift towards the MSB.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 4'b1100;

  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] s, input logic d);
    return {s[MISR_W-2:0], (^(s & MISR_TAPS)) ^ d};
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] p);
    return {p[LFSR_W-2:0], ^(p & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/s27_bist_misr.sv
// rtl/s27_bist_misr.sv - 16-bit serial-input MISR with clear, enable and look-ahead next value
module s27_bist_misr
  import s27_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              sin,
  output logic [MISR_W-1:0] sig,
  output logic [MISR_W-1:0] sig_next
);

  // sig_next lets the controller register pass on the same edge the last sample lands.
  always_comb begin
    sig_next = misr_step(sig, sin);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/s27_bist_ctrl.sv
// rtl/s27_bist_ctrl.sv - BIST sequencer driving one s27 core; optional S27_BIST_ONES_CNT_EN adds ones_cnt
module s27_bist_ctrl
  import s27_bist_pkg::*;
#(
  parameter logic [15:0] NUM_PATTERNS = 16'd64,
  parameter logic [7:0]  RST_CYCLES   = 8'd4,
  parameter logic [3:0]  LFSR_SEED    = 4'b0001,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
`ifdef S27_BIST_ONES_CNT_EN
  ,
  parameter logic [15:0] GOLDEN_ONES  = 16'h0000
`endif
) (
  input  logic        blif_clk_net,
  input  logic        blif_reset_net,
  input  logic        start,
  input  logic        abort,
  input  logic        dut_g17,
  output logic        dut_rst,
  output logic        dut_g0,
  output logic        dut_g1,
  output logic        dut_g2,
  output logic        dut_g3,
  output logic        busy,
  output logic        done,
  output logic        pass,
`ifdef S27_BIST_ONES_CNT_EN
  output logic [15:0] ones_cnt,
`endif
  output logic [15:0] signature
);

  bist_state_t       state;
  logic [7:0]        rst_cnt;
  logic [15:0]       pat_cnt;
  logic [LFSR_W-1:0] pat;
  logic [LFSR_W-1:0] dut_g;

  logic              start_accept;
  logic              misr_en;
  logic              last_sample;
  logic              pass_next;
  logic [MISR_W-1:0] sig_next;

  assign start_accept = start && !abort && (state == IDLE || state == DONE);
  assign misr_en      = (state == RUN) && !abort;
  assign last_sample  = (pat_cnt == NUM_PATTERNS - 16'd1);

  assign dut_g0 = dut_g[0];
  assign dut_g1 = dut_g[1];
  assign dut_g2 = dut_g[2];
  assign dut_g3 = dut_g[3];

  s27_bist_misr u_misr (
    .clk      (blif_clk_net),
    .rst      (blif_reset_net),
    .clr      (start_accept),
    .en       (misr_en),
    .sin      (dut_g17),
    .sig      (signature),
    .sig_next (sig_next)
  );

`ifdef S27_BIST_ONES_CNT_EN
  logic [15:0] ones_next;

  assign ones_next = ones_cnt + {15'd0, dut_g17};
  assign pass_next = (sig_next == GOLDEN_SIG) && (ones_next == GOLDEN_ONES);

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net || start_accept) begin
      ones_cnt <= '0;
    end else if (misr_en) begin
      ones_cnt <= ones_next;
    end
  end
`else
  assign pass_next = (sig_next == GOLDEN_SIG);
`endif

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      state   <= IDLE;
      rst_cnt <= '0;
      pat_cnt <= '0;
      pat     <= LFSR_SEED;
      dut_g   <= '0;
      dut_rst <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else if (abort) begin
      state   <= IDLE;
      dut_g   <= '0;
      dut_rst <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RST;
            rst_cnt <= RST_CYCLES - 8'd1;
            pat_cnt <= '0;
            pat     <= LFSR_SEED;
            dut_g   <= '0;
            dut_rst <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
          end
        end
        RST: begin
          if (rst_cnt == 8'd0) begin
            state   <= RUN;
            pat_cnt <= '0;
            dut_rst <= 1'b0;
            dut_g   <= pat;
          end else begin
            rst_cnt <= rst_cnt - 8'd1;
          end
        end
        RUN: begin
          pat_cnt <= pat_cnt + 16'd1;
          // On the final sample the pattern is left in place so the core inputs hold in DONE.
          if (last_sample) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= pass_next;
          end else begin
            pat   <= lfsr_step(pat);
            dut_g <= lfsr_step(pat);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// tb/tb_s27_bist_ctrl.sv - self-checking bench: stubbed-G17 instance plus an instance driving an s27 core model
module tb_s27_bist_ctrl;

  localparam int RC   = 2;
  localparam int NP   = 4;
  localparam int RC_B = 4;
  localparam int NP_B = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, abort_a, g17_a;
  logic        drst_a, busy_a, done_a, pass_a;
  logic [3:0]  g_a;
  logic [15:0] sig_a;
  logic        start_b, abort_b, g17_b;
  logic        drst_b, busy_b, done_b, pass_b;
  logic [3:0]  g_b;
  logic [15:0] sig_b;
`ifdef S27_BIST_ONES_CNT_EN
  logic [15:0] ones_a, ones_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  s27_bist_ctrl #(
    .NUM_PATTERNS (16'(NP)),
    .RST_CYCLES   (8'(RC)),
    .LFSR_SEED    (4'b0001),
    .GOLDEN_SIG   (16'h000F)
`ifdef S27_BIST_ONES_CNT_EN
    , .GOLDEN_ONES (16'd4)
`endif
  ) dut_a (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .start          (start_a),
    .abort          (abort_a),
    .dut_g17        (g17_a),
    .dut_rst        (drst_a),
    .dut_g0         (g_a[0]),
    .dut_g1         (g_a[1]),
    .dut_g2         (g_a[2]),
    .dut_g3         (g_a[3]),
    .busy           (busy_a),
    .done           (done_a),
    .pass           (pass_a),
`ifdef S27_BIST_ONES_CNT_EN
    .ones_cnt       (ones_a),
`endif
    .signature      (sig_a)
  );

  s27_bist_ctrl #(
    .NUM_PATTERNS (16'(NP_B)),
    .RST_CYCLES   (8'(RC_B)),
    .LFSR_SEED    (4'b0001),
    .GOLDEN_SIG   (16'h0000)
  ) dut_b (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .start          (start_b),
    .abort          (abort_b),
    .dut_g17        (g17_b),
    .dut_rst        (drst_b),
    .dut_g0         (g_b[0]),
    .dut_g1         (g_b[1]),
    .dut_g2         (g_b[2]),
    .dut_g3         (g_b[3]),
    .busy           (busy_b),
    .done           (done_b),
    .pass           (pass_b),
`ifdef S27_BIST_ONES_CNT_EN
    .ones_cnt       (ones_b),
`endif
    .signature      (sig_b)
  );

  // s27 netlist evaluated from state {G7,G6,G5} and inputs {G3..G0}; returns {G7',G6',G5',G17}.
  function automatic logic [3:0] s27_eval(input logic [2:0] st, input logic [3:0] g);
    logic g14, g8, g9, g10, g11, g12, g13, g15, g16;
    g14 = ~g[0];
    g12 = ~(g[1] | st[2]);
    g8  = g14 & st[1];
    g15 = g12 | g8;
    g16 = g[3] | g8;
    g9  = ~(g16 & g15);
    g11 = ~(st[0] | g9);
    g10 = ~(g14 | g11);
    g13 = ~(g[2] | g12);
    return {g13, g11, g10, ~g11};
  endfunction

  logic [2:0] core_st;
  logic [3:0] core_out;
  always_comb core_out = s27_eval(core_st, g_b);
  assign g17_b = core_out[0];
  always @(posedge clk) core_st <= drst_b ? 3'b000 : core_out[3:1];

  function automatic logic [15:0] misr_add(input logic [15:0] s, input logic d);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10] ^ d;
    return (s << 1) | {15'd0, fb};
  endfunction

  function automatic logic [3:0] lfsr_next(input logic [3:0] p);
    return ((p << 1) & 4'hE) | {3'd0, p[3] ^ p[2]};
  endfunction

  logic [3:0]  obs_g    [0:15];
  logic [2:0]  obs_flags[0:15];
  logic [15:0] obs_sig;
  logic        obs_pass;
  logic [15:0] obs_ones;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic record(input int j);
    obs_g[j]     = g_a;
    obs_flags[j] = {busy_a, drst_a, done_a};
  endtask

  // Start dut_a, feed bits[j-1] on G17 before edge t+j, optional extra start pulses at sp1/sp2.
  task automatic drive_a(input logic [15:0] bits, input int sp1, input int sp2);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    record(0);
    for (int j = 1; j <= RC + NP; j++) begin
      g17_a   = bits[j-1];
      start_a = (j == sp1) || (j == sp2);
      step();
      start_a = 1'b0;
      record(j);
    end
    obs_sig  = sig_a;
    obs_pass = pass_a;
`ifdef S27_BIST_ONES_CNT_EN
    obs_ones = ones_a;
`else
    obs_ones = 16'd0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_cmp += 6;
    if (drst_a !== 1'b1) begin n_bad++; $display("FAIL reset_dut_rst got %b want 1", drst_a); end
    if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy_a); end
    if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done_a); end
    if (pass_a !== 1'b0) begin n_bad++; $display("FAIL reset_pass got %b want 0", pass_a); end
    if (sig_a !== 16'h0000) begin n_bad++; $display("FAIL reset_sig got %h want 0000", sig_a); end
    if (g_a !== 4'b0000) begin n_bad++; $display("FAIL reset_g got %b want 0000", g_a); end
  endtask

  task automatic test_known_answers();
    logic [3:0] want_pat [0:3];
    want_pat[0] = 4'b0001; want_pat[1] = 4'b0010; want_pat[2] = 4'b0100; want_pat[3] = 4'b1001;
    drive_a(16'hFFFF, -1, -1);
    for (int k = 0; k < NP; k++) begin
      n_cmp++;
      if (obs_g[RC+k] !== want_pat[k]) begin
        n_bad++; $display("FAIL ka_pattern_%0d got %b want %b", k, obs_g[RC+k], want_pat[k]);
      end
    end
    n_cmp += 3;
    if (obs_sig !== 16'h000F) begin n_bad++; $display("FAIL ka_ones_sig got %h want 000f", obs_sig); end
    if (obs_pass !== 1'b1) begin n_bad++; $display("FAIL ka_ones_pass got %b want 1", obs_pass); end
    if (obs_flags[RC+NP] !== 3'b001) begin
      n_bad++; $display("FAIL ka_ones_done got %b want 001", obs_flags[RC+NP]);
    end
    drive_a(16'h0000, -1, -1);
    n_cmp += 3;
    if (obs_sig !== 16'h0000) begin n_bad++; $display("FAIL ka_zero_sig got %h want 0000", obs_sig); end
    if (obs_pass !== 1'b0) begin n_bad++; $display("FAIL ka_zero_pass got %b want 0", obs_pass); end
    if (obs_flags[RC+NP] !== 3'b001) begin
      n_bad++; $display("FAIL ka_zero_done got %b want 001", obs_flags[RC+NP]);
    end
  endtask

  // Random G17 runs, with optional ignored start pulses, against a sequence-level model.
  task automatic test_random_runs(input int runs, input bit extra_starts);
    logic [15:0] bits, esig, eones;
    logic [3:0]  epat [0:15];
    logic [3:0]  p, eg;
    logic [2:0]  ef;
    logic        epass;
    for (int r = 0; r < runs; r++) begin
      bits = 16'($urandom);
      if (extra_starts) drive_a(bits, 1, RC + 2);
      else drive_a(bits, -1, -1);
      esig = 16'h0000; eones = 16'd0; p = 4'b0001;
      for (int k = 0; k < NP; k++) begin
        epat[k] = p;
        p = lfsr_next(p);
        esig = misr_add(esig, bits[RC+k]);
        eones += 16'(bits[RC+k]);
      end
`ifdef S27_BIST_ONES_CNT_EN
      epass = (esig == 16'h000F) && (eones == 16'd4);
`else
      epass = (esig == 16'h000F);
`endif
      for (int j = 0; j <= RC + NP; j++) begin
        eg = (j < RC) ? 4'b0000 : epat[(j - RC < NP) ? j - RC : NP - 1];
        ef = {j < RC + NP, j < RC, j == RC + NP};
        n_cmp++;
        if ({obs_flags[j], obs_g[j]} !== {ef, eg}) begin
          n_bad++;
          $display("FAIL rand_cycle_%0d busy/rst/done/g got %b want %b", j, {obs_flags[j], obs_g[j]}, {ef, eg});
        end
      end
      n_cmp += 2;
      if (obs_sig !== esig) begin n_bad++; $display("FAIL rand_sig got %h want %h", obs_sig, esig); end
      if (obs_pass !== epass) begin n_bad++; $display("FAIL rand_pass got %b want %b", obs_pass, epass); end
`ifdef S27_BIST_ONES_CNT_EN
      n_cmp++;
      if (obs_ones !== eones) begin n_bad++; $display("FAIL rand_ones got %0d want %0d", obs_ones, eones); end
`endif
    end
  endtask

  task automatic test_restart_from_done();
    int j;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    n_cmp += 4;
    if (done_a !== 1'b0) begin n_bad++; $display("FAIL restart_done got %b want 0", done_a); end
    if (pass_a !== 1'b0) begin n_bad++; $display("FAIL restart_pass got %b want 0", pass_a); end
    if ({busy_a, drst_a} !== 2'b11) begin n_bad++; $display("FAIL restart_busy_rst got %b want 11", {busy_a, drst_a}); end
    if (sig_a !== 16'h0000) begin n_bad++; $display("FAIL restart_sig got %h want 0000", sig_a); end
    for (j = 1; j <= 40; j++) begin
      g17_a = 1'($urandom);
      step();
      if (done_a) break;
    end
    n_cmp++;
    if (j !== RC + NP) begin n_bad++; $display("FAIL restart_latency got %0d want %0d", j, RC + NP); end
  endtask

  task automatic test_abort_start_same();
    logic [15:0] prev;
    prev    = sig_a;
    start_a = 1'b1;
    abort_a = 1'b1;
    step();
    start_a = 1'b0;
    abort_a = 1'b0;
    n_cmp += 3;
    if ({busy_a, drst_a, done_a, pass_a} !== 4'b0100) begin
      n_bad++; $display("FAIL abstart_flags got %b want 0100", {busy_a, drst_a, done_a, pass_a});
    end
    if (sig_a !== prev) begin n_bad++; $display("FAIL abstart_sig got %h want %h", sig_a, prev); end
    step();
    if (busy_a !== 1'b0) begin n_bad++; $display("FAIL abstart_stay_idle got %b want 0", busy_a); end
  endtask

  task automatic test_abort_rerun();
    logic [15:0] bits, esig;
    bits    = 16'($urandom);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int j = 1; j <= RC + 1; j++) begin
      g17_a = bits[j-1];
      step();
    end
    abort_a = 1'b1;
    g17_a   = bits[RC+1];
    step();
    abort_a = 1'b0;
    esig = misr_add(16'h0000, bits[RC]);
    n_cmp += 3;
    if ({busy_a, drst_a, done_a, pass_a} !== 4'b0100) begin
      n_bad++; $display("FAIL abort_flags got %b want 0100", {busy_a, drst_a, done_a, pass_a});
    end
    if (g_a !== 4'b0000) begin n_bad++; $display("FAIL abort_g got %b want 0000", g_a); end
    if (sig_a !== esig) begin n_bad++; $display("FAIL abort_sig_kept got %h want %h", sig_a, esig); end
    drive_a(bits, -1, -1);
    esig = 16'h0000;
    for (int k = 0; k < NP; k++) esig = misr_add(esig, bits[RC+k]);
    n_cmp += 2;
    if (obs_sig !== esig) begin n_bad++; $display("FAIL abort_rerun_sig got %h want %h", obs_sig, esig); end
    if (obs_flags[RC+NP] !== 3'b001) begin
      n_bad++; $display("FAIL abort_rerun_done got %b want 001", obs_flags[RC+NP]);
    end
  endtask

  task automatic test_reset_mid();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    g17_a = 1'b1;
    for (int j = 0; j < RC + 2; j++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp += 3;
    if ({busy_a, drst_a, done_a, pass_a} !== 4'b0100) begin
      n_bad++; $display("FAIL midreset_flags got %b want 0100", {busy_a, drst_a, done_a, pass_a});
    end
    if (g_a !== 4'b0000) begin n_bad++; $display("FAIL midreset_g got %b want 0000", g_a); end
    if (sig_a !== 16'h0000) begin n_bad++; $display("FAIL midreset_sig got %h want 0000", sig_a); end
  endtask

  task automatic test_core_runs();
    logic [15:0] esig, eones, first_sig;
    logic [3:0]  p, out;
    logic [2:0]  st;
    int          j;
    esig = 16'h0000; eones = 16'd0; p = 4'b0001; st = 3'b000;
    for (int k = 0; k < NP_B; k++) begin
      out   = s27_eval(st, p);
      esig  = misr_add(esig, out[0]);
      eones += 16'(out[0]);
      st    = out[3:1];
      p     = lfsr_next(p);
    end
    first_sig = 16'hxxxx;
    for (int r = 0; r < 2; r++) begin
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      for (j = 1; j <= 200; j++) begin
        step();
        if (done_b) break;
      end
      n_cmp += 3;
      if (j !== RC_B + NP_B) begin n_bad++; $display("FAIL core_latency_%0d got %0d want %0d", r, j, RC_B + NP_B); end
      if (sig_b !== esig) begin n_bad++; $display("FAIL core_sig_%0d got %h want %h", r, sig_b, esig); end
`ifdef S27_BIST_ONES_CNT_EN
      if (pass_b !== ((esig == 16'h0000) && (eones == 16'd0))) begin
`else
      if (pass_b !== (esig == 16'h0000)) begin
`endif
        n_bad++; $display("FAIL core_pass_%0d got %b want %b", r, pass_b, esig == 16'h0000);
      end
`ifdef S27_BIST_ONES_CNT_EN
      n_cmp++;
      if (ones_b !== eones) begin n_bad++; $display("FAIL core_ones_%0d got %0d want %0d", r, ones_b, eones); end
`endif
      if (r == 1) begin
        n_cmp++;
        if (sig_b !== first_sig) begin n_bad++; $display("FAIL core_repeat got %h want %h", sig_b, first_sig); end
      end
      first_sig = sig_b;
    end
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; abort_a = 1'b0; g17_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0;
    test_reset();
    test_known_answers();
    test_random_runs(8, 1'b0);
    test_random_runs(4, 1'b1);
    test_restart_from_done();
    test_abort_start_same();
    test_abort_rerun();
    test_reset_mid();
    test_core_runs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
